instruction_encoder: RTL
========================

Name: instruction_encoder

Overview:
- Packs discrete instruction fields into the 16-bit instruction word consumed by instruction_decoder. It is the encoding side of the same word format.
- Sits between the sequencer/assembler-side logic and instruction memory or the fetch path.
- Accepts fields over a valid/ready handshake, encodes them, and buffers the words in a small FIFO.
- Presents the words downstream over a second valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries. Power of two, minimum 2.
- PTR_W, 2, log2(DEPTH). Derived, not overridden.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- enable  input  1  when low, the upstream side stalls (in_ready forced 0); the downstream side is unaffected
- in_valid  input  1  upstream fields valid
- in_ready  output  1  encoder can accept
- fmt_imm  input  1  1 = immediate format, 0 = register format
- opcode  input  4  operation code
- rDadrs  input  3  destination register
- flag  input  1  instruction flag bit
- rAadrs  input  3  source A register (register format only)
- rBadrs  input  3  source B register (register format only)
- imm  input  8  immediate (immediate format only)
- out_valid  output  1  instruct holds a valid word
- out_ready  input  1  downstream accepts
- instruct  output  16  encoded instruction word
- count  output  PTR_W+1  FIFO occupancy, 0..DEPTH

Behaviour:
Word format, common to both formats:
- [15:12] = opcode
- [11:9] = rDadrs
- [8] = flag

Lower byte by format:
- Immediate format: [7:0] = imm. rAadrs and rBadrs are ignored.
- Register format: [7:5] = rAadrs, [4:2] = rBadrs, [1:0] = 2'b00. imm is ignored.

Encoding and push:
- Encoding is combinational.
- The word is written into the FIFO on a push = in_valid & in_ready at the rising edge.

Pop:
- pop = out_valid & out_ready.

Ready/valid:
- in_ready = enable & (count != DEPTH). It is combinational and does not depend on out_ready. A full FIFO refuses input even if a pop happens in the same cycle.
- out_valid = (count != 0).
- instruct = entry at the read pointer when out_valid = 1, else 16'h0000.

Latency:
- A word pushed into an empty FIFO at edge N is visible with out_valid = 1 after edge N (one cycle).
- No bypass path.

Ordering:
- Strict FIFO order.
- Pointers wrap modulo DEPTH.
- count tracks pushes minus pops.

Simultaneous push and pop:
- Allowed whenever 0 < count < DEPTH.
- count is unchanged and both pointers advance.
- At count = 0 only the push occurs. At count = DEPTH only the pop occurs, since in_ready = 0.

Stability:
- While out_valid = 1 and out_ready = 0, instruct must not change, even while pushes continue.
- Upstream must hold its fields stable while in_valid = 1 and in_ready = 0. The encoder does not check this.

Reset (reset_n = 0 at a rising edge):
- Pointers and count clear to 0, so out_valid = 0, instruct = 16'h0000 and count = 0.
- in_ready follows enable on the next cycle.
- Reset mid-stream discards all buffered words. Handshakes asserted in the reset cycle are ignored.
- Storage contents need not be cleared.

enable low:
- No push occurs, but pops continue.
- Dropping enable mid-handshake is legal; the word is simply not taken.

Test Plan:
- Reset, then one immediate-format push: opcode=4'hA, rD=3'd5, flag=1, imm=8'h3C with out_ready=1. Required: instruct=16'hAB3C with out_valid=1 exactly one cycle after the push; count returns to 0 after the pop.
- Register-format push: opcode=4'h3, rD=3'd2, flag=0, rA=3'd7, rB=3'd1, imm=8'hFF. Required: instruct=16'h34E4, imm ignored.
- Hold out_ready=0 and push 5 distinct words. Required: in_ready drops after the 4th push, count=4, the 5th word is not taken, and instruct stays on word 1 the whole time.
- Then out_ready=1 with no input. Required: words 1-4 emerge in order on consecutive cycles, then out_valid=0 and instruct=16'h0000.
- With count=2, simultaneous push and pop for 10 cycles using an incrementing imm. Required: count stays 2, pointers wrap, and the output order matches the input order.
- Fill to 3, assert reset_n=0 for one cycle with in_valid=1. Required: count=0 and out_valid=0 next cycle, and none of the pending words appear.
- Then hold enable=0 with in_valid=1. Required: in_ready=0, count stays 0, and out_valid stays 0.

Source files
------------

// File: rtl/instruction_encoder.sv
// Instruction field encoder with output FIFO.
// Packs opcode/register/flag/immediate fields into the 16-bit instruction
// word and buffers encoded words for the fetch path over valid/ready.
module instruction_encoder #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             fmt_imm,
  input  logic [3:0]       opcode,
  input  logic [2:0]       rDadrs,
  input  logic             flag,
  input  logic [2:0]       rAadrs,
  input  logic [2:0]       rBadrs,
  input  logic [7:0]       imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      instruct,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [15:0]    mem_q [DEPTH];
  logic [15:0]    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [15:0] enc_word;
  logic        push;
  logic        pop;

  // Field packing: common upper byte, lower byte selected by format.
  always_comb begin
    enc_word = '0;
    enc_word[15:12] = opcode;
    enc_word[11:9]  = rDadrs;
    enc_word[8]     = flag;
    if (fmt_imm) begin
      enc_word[7:0] = imm;
    end else begin
      enc_word[7:5] = rAadrs;
      enc_word[4:2] = rBadrs;
      enc_word[1:0] = 2'b00;
    end
  end

  // Handshakes, FIFO next-state and registered-output read mux.
  always_comb begin
    in_ready  = enable && (count_q != FULL);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = enc_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    instruct = out_valid ? mem_q[rd_ptr_q] : '0;
    count    = count_q;
  end

  // Pointer and occupancy registers, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; a cleared count hides any stale entries.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule
